// File: rtl/mult_feed_pkg.sv
// Shared types for the multiplier-array feed controller: FSM state encoding
// and the legal range of the control-to-data lead.
package mult_feed_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CTRL_LEAD_MIN = 0;
  localparam int CTRL_LEAD_MAX = 1;

  function automatic bit ctrl_lead_legal(input int lead);
    return (lead >= CTRL_LEAD_MIN) && (lead <= CTRL_LEAD_MAX);
  endfunction

endpackage

// File: rtl/mult_feed_ctrl_if.sv
// Job config, upstream vector stream and array-side feed of mult_feed_ctrl.
// Member names are from the controller's point of view (i_ = into it).
interface mult_feed_ctrl_if #(
  parameter int IN_DATA_TYPE = 8,
  parameter int NUM_PES      = 32,
  parameter int CNT_W        = 16
);
  localparam int BUS_W = NUM_PES * IN_DATA_TYPE;

  logic             i_cfg_valid;
  logic [CNT_W-1:0] i_cfg_cnt;
  logic             i_cfg_reuse_w;
  logic             i_abort;
  logic             i_data_valid;
  logic [BUS_W-1:0] i_data_bus;
  logic             o_data_ready;
  logic             o_valid;
  logic             o_stationary;
  logic [BUS_W-1:0] o_data_bus;
  logic             o_busy;
  logic             o_done;

  // Master is the job/stream source; slave is the controller itself.
  modport master (
    output i_cfg_valid, i_cfg_cnt, i_cfg_reuse_w, i_abort, i_data_valid, i_data_bus,
    input  o_data_ready, o_valid, o_stationary, o_data_bus, o_busy, o_done
  );

  modport slave (
    input  i_cfg_valid, i_cfg_cnt, i_cfg_reuse_w, i_abort, i_data_valid, i_data_bus,
    output o_data_ready, o_valid, o_stationary, o_data_bus, o_busy, o_done
  );

endinterface

// File: rtl/mult_feed_dly.sv
// Data/done delay line aligning vectors behind their control beat.
// MULT_FEED_ZERO_GATE_EN: bubble stages carry zero instead of holding the last vector.
module mult_feed_dly #(
  parameter int W     = 256,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_done,
  input  logic         i_flush,
  output logic [W-1:0] o_data,
  output logic         o_done
);

  logic [DEPTH-1:0]        r_vld;
  logic [DEPTH-1:0]        r_done;
  logic [DEPTH-1:0][W-1:0] r_data;
  logic [DEPTH-1:0]        w_vld_prev;
  logic [DEPTH-1:0]        w_done_prev;
  logic [DEPTH-1:0][W-1:0] w_data_prev;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_vld_prev  = i_valid;
      assign w_done_prev = i_done;
      assign w_data_prev = i_data;
    end else begin : g_multi
      assign w_vld_prev  = {r_vld[DEPTH-2:0], i_valid};
      assign w_done_prev = {r_done[DEPTH-2:0], i_done};
      assign w_data_prev = {r_data[DEPTH-2:0], i_data};
    end
  endgenerate

  // An abort kills pending done flags but lets already-issued data drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_done <= '0;
      r_data <= '0;
    end else begin
      r_vld  <= w_vld_prev;
      r_done <= w_done_prev & {DEPTH{~i_flush}};
      for (int k = 0; k < DEPTH; k++) begin
`ifdef MULT_FEED_ZERO_GATE_EN
        r_data[k] <= w_vld_prev[k] ? w_data_prev[k] : '0;
`else
        if (w_vld_prev[k]) r_data[k] <= w_data_prev[k];
`endif
      end
    end
  end

  assign o_data = r_data[DEPTH-1];
  assign o_done = r_done[DEPTH-1] & r_vld[DEPTH-1];

endmodule

// File: rtl/mult_feed_ctrl.sv
// Sequences weight-load and streaming beats from a ready/valid source into the
// multiplier-switch array; bubble data behaviour set by MULT_FEED_ZERO_GATE_EN.
module mult_feed_ctrl
  import mult_feed_pkg::*;
#(
  parameter int IN_DATA_TYPE = 8,
  parameter int NUM_PES      = 32,
  parameter int CNT_W        = 16,
  parameter int CTRL_LEAD    = 1
) (
  input  logic             clk,
  input  logic             rst,
  mult_feed_ctrl_if.slave  bus
);

  localparam int BUS_W = NUM_PES * IN_DATA_TYPE;
  // Out-of-range leads fall back to the deepest supported alignment.
  localparam int LEAD  = ctrl_lead_legal(CTRL_LEAD) ? CTRL_LEAD : CTRL_LEAD_MAX;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cfg_cnt;
  logic             r_valid;
  logic             r_stat;
  logic             r_done_direct;
  logic             w_ready;
  logic             w_acc;
  logic             w_start;
  logic             w_last;
  logic             w_last_beat;
  logic             w_dly_done;
  logic [BUS_W-1:0] w_dly_data;

  // A beat presented alongside abort is dropped so no control is issued for it.
  assign w_acc       = bus.i_data_valid & w_ready & ~bus.i_abort;
  assign w_start     = (r_state == IDLE) & bus.i_cfg_valid & ~bus.i_abort;
  assign w_last      = ((r_state == LOAD_W) && (r_cfg_cnt == '0)) ||
                       ((r_state == STREAM) && ((r_cnt + CNT_W'(1)) == r_cfg_cnt));
  assign w_last_beat = w_acc & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      LOAD_W, STREAM: w_ready = 1'b1;
      default:        w_ready = 1'b0;
    endcase
    if (bus.i_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_cfg_valid) begin
            if (!bus.i_cfg_reuse_w)        w_next = LOAD_W;
            else if (bus.i_cfg_cnt != '0)  w_next = STREAM;
            else                           w_next = DONE;
          end
        end
        LOAD_W:  if (w_acc) w_next = (r_cfg_cnt != '0) ? STREAM : DONE;
        STREAM:  if (w_last_beat) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Control stage, latched job config and streaming-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_stat        <= 1'b0;
      r_done_direct <= 1'b0;
      r_cfg_cnt     <= '0;
      r_cnt         <= '0;
    end else begin
      r_valid       <= w_acc;
      r_stat        <= w_acc & (r_state == LOAD_W);
      r_done_direct <= w_start & bus.i_cfg_reuse_w & (bus.i_cfg_cnt == '0);
      if (w_start) begin
        r_cfg_cnt <= bus.i_cfg_cnt;
        r_cnt     <= '0;
      end else if (w_acc && (r_state == STREAM)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  mult_feed_dly #(
    .W     (BUS_W),
    .DEPTH (LEAD + 1)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_acc),
    .i_data  (bus.i_data_bus),
    .i_done  (w_last_beat),
    .i_flush (bus.i_abort),
    .o_data  (w_dly_data),
    .o_done  (w_dly_done)
  );

  assign bus.o_data_ready = w_ready;
  assign bus.o_valid      = r_valid;
  assign bus.o_stationary = r_stat;
  assign bus.o_data_bus   = w_dly_data;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_done       = w_dly_done | r_done_direct;

endmodule

// File: tb/tb_mult_feed_ctrl.sv
// Directed bench for mult_feed_ctrl; bubble expectations follow MULT_FEED_ZERO_GATE_EN.
module tb_mult_feed_ctrl;

  localparam int IN_DATA_TYPE = 8;
  localparam int NUM_PES      = 32;
  localparam int CNT_W        = 16;
  localparam int CTRL_LEAD    = 1;
  localparam int BUS_W        = NUM_PES * IN_DATA_TYPE;

`ifdef MULT_FEED_ZERO_GATE_EN
  localparam bit ZERO_GATE = 1'b1;
`else
  localparam bit ZERO_GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;

  mult_feed_ctrl_if #(
    .IN_DATA_TYPE (IN_DATA_TYPE),
    .NUM_PES      (NUM_PES),
    .CNT_W        (CNT_W)
  ) bus ();

  mult_feed_ctrl #(
    .IN_DATA_TYPE (IN_DATA_TYPE),
    .NUM_PES      (NUM_PES),
    .CNT_W        (CNT_W),
    .CTRL_LEAD    (CTRL_LEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] vec(input logic [7:0] lane);
    return {NUM_PES{lane}};
  endfunction

  // What o_data_bus shows on a bubble after the given lane value was last issued.
  function automatic logic [BUS_W-1:0] bubble(input logic [7:0] held);
    return ZERO_GATE ? '0 : vec(held);
  endfunction

  task automatic checkOutput(input string tag, input logic [BUS_W-1:0] obs,
                             input logic [BUS_W-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Control bits packed as {ready, valid, stationary, busy, done}.
  task automatic expectCtl(input string tag, input logic [4:0] exp);
    checkOutput(tag,
                BUS_W'({bus.o_data_ready, bus.o_valid, bus.o_stationary, bus.o_busy, bus.o_done}),
                BUS_W'(exp));
  endtask

  task automatic expectData(input string tag, input logic [BUS_W-1:0] exp);
    checkOutput(tag, bus.o_data_bus, exp);
  endtask

  task automatic applyStimulus(input logic cfgV, input logic [CNT_W-1:0] cnt,
                               input logic reuse, input logic abort,
                               input logic dv, input logic [7:0] lane);
    @(posedge clk);
    #1;
    bus.i_cfg_valid   = cfgV;
    bus.i_cfg_cnt     = cnt;
    bus.i_cfg_reuse_w = reuse;
    bus.i_abort       = abort;
    bus.i_data_valid  = dv;
    bus.i_data_bus    = vec(lane);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bus.i_cfg_valid   = 1'b0;
    bus.i_cfg_cnt     = '0;
    bus.i_cfg_reuse_w = 1'b0;
    bus.i_abort       = 1'b0;
    bus.i_data_valid  = 1'b0;
    bus.i_data_bus    = '0;
    repeat (2) @(posedge clk);
    #1;
    expectCtl("reset ctl", 5'b00000);
    expectData("reset data", '0);
    rst = 1'b0;

    // Weight load plus four streaming beats, data every cycle.
    applyStimulus(1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 8'h00); expectCtl("t1 cfg", 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h11); expectCtl("t1 load", 5'b10010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h21); expectCtl("t1 stat", 5'b11110);
    expectData("t1 stat data", '0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h22); expectCtl("t1 s1", 5'b11010);
    expectData("t1 s1 data", vec(8'h11));
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h23); expectCtl("t1 s2", 5'b11010);
    expectData("t1 s2 data", vec(8'h21));
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h24); expectCtl("t1 s3", 5'b11010);
    expectData("t1 s3 data", vec(8'h22));
    idleCycle(); expectCtl("t1 done st", 5'b01010); expectData("t1 s4 data", vec(8'h23));
    idleCycle(); expectCtl("t1 done", 5'b00001);    expectData("t1 last data", vec(8'h24));
    idleCycle(); expectCtl("t1 after", 5'b00000);   expectData("t1 bubble", bubble(8'h24));

    // Reuse weights, three beats with gaps upstream.
    applyStimulus(1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t2 cfg", 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h31); expectCtl("t2 b1", 5'b10010);
    idleCycle();                                          expectCtl("t2 gap1", 5'b11010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h32); expectCtl("t2 b2", 5'b10010);
    expectData("t2 b1 data", vec(8'h31));
    idleCycle(); expectCtl("t2 gap2", 5'b11010); expectData("t2 bubble1", bubble(8'h31));
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h33); expectCtl("t2 b3", 5'b10010);
    expectData("t2 b2 data", vec(8'h32));
    idleCycle(); expectCtl("t2 done st", 5'b01010); expectData("t2 bubble2", bubble(8'h32));
    idleCycle(); expectCtl("t2 done", 5'b00001);    expectData("t2 b3 data", vec(8'h33));

    // Zero-beat job reusing weights.
    applyStimulus(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t3 cfg", 5'b00000);
    idleCycle(); expectCtl("t3 done", 5'b00011);
    idleCycle(); expectCtl("t3 idle", 5'b00000);

    // Abort on the second of eight streaming beats.
    applyStimulus(1'b1, 16'd8, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t4 cfg", 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h41); expectCtl("t4 b1", 5'b10010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 8'h42); expectCtl("t4 abort", 5'b11010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h43); expectCtl("t4 idle", 5'b00000);
    expectData("t4 trailing", vec(8'h41));
    idleCycle(); expectCtl("t4 no done1", 5'b00000); expectData("t4 drained", bubble(8'h41));
    idleCycle(); expectCtl("t4 no done2", 5'b00000);

    // Config while busy is ignored; the next one after the job is taken.
    applyStimulus(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t5 cfg", 5'b00000);
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 8'h51); expectCtl("t5 b1", 5'b10010);
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 8'h52); expectCtl("t5 b2", 5'b11010);
    idleCycle(); expectCtl("t5 done st", 5'b01010); expectData("t5 b1 data", vec(8'h51));
    applyStimulus(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t5 done", 5'b00001);
    expectData("t5 b2 data", vec(8'h52));
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h61); expectCtl("t5 new b1", 5'b10010);
    idleCycle(); expectCtl("t5 new done st", 5'b01010);
    idleCycle(); expectCtl("t5 new done", 5'b00001); expectData("t5 new data", vec(8'h61));

    // Abort and config in the same idle cycle: no job.
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 8'h00); expectCtl("t6 cfg+abort", 5'b00000);
    idleCycle(); expectCtl("t6 not started", 5'b00000);

    // Weight load only.
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00); expectCtl("t7 cfg", 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h81); expectCtl("t7 load", 5'b10010);
    idleCycle(); expectCtl("t7 done st", 5'b01110);
    idleCycle(); expectCtl("t7 done", 5'b00001); expectData("t7 data", vec(8'h81));

    // Asynchronous reset in the middle of a job.
    applyStimulus(1'b1, 16'd4, 1'b1, 1'b0, 1'b0, 8'h00); expectCtl("t8 cfg", 5'b00000);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h71); expectCtl("t8 b1", 5'b10010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h72); expectCtl("t8 b2", 5'b11010);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 8'h73); expectCtl("t8 b3", 5'b11010);
    expectData("t8 b1 data", vec(8'h71));
    #3 rst = 1'b1;
    #1;
    expectCtl("t8 rst ctl", 5'b00000);
    expectData("t8 rst data", '0);
    @(posedge clk);
    #1 rst = 1'b0;
    idleCycle(); expectCtl("t8 post1", 5'b00000);
    idleCycle(); expectCtl("t8 post2", 5'b00000); expectData("t8 post data", '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
